// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit CLA group per stage.
// Valid/ready framed, global stall, flags Cout/Ovf/Zero registered with S.
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int NG = WIDTH / 4;

    // Fully expanded lookahead carries c0..c4 of one 4-bit group.
    function automatic logic [4:0] cla_carries(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       ci
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0]
             | (p[0] & ci);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & ci);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic             stall;
    logic             adv;
    logic [WIDTH-1:0] y_eff;
    logic             c_in0;

    // Inputs of the final (output) stage.
    logic             lst_v;
    logic             lst_c;
    logic [WIDTH-1:0] lst_xs;
    logic [3:0]       lst_y;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    // Global stall and operand conditioning for subtraction.
    always_comb begin
        stall = out_valid_q & ~out_ready;
        adv   = ~stall;
        y_eff = Sub ? ~Y : Y;
        c_in0 = Cin ^ Sub;
    end

    // Stage k owns group k. Its register holds the lower sum slices merged
    // with the not-yet-added upper X bits, plus only the upper Yeff bits
    // that later stages still need.
    for (genvar k = 0; k < NG - 1; k++) begin : g_stage
        localparam int LO = 4 * k;
        localparam int YL = 4 * (k + 1);

        logic             v_i;
        logic             c_i;
        logic [WIDTH-1:0] xs_i;
        logic [3:0]       yg_i;
        logic [WIDTH-1:YL] yr_i;
        logic [4:0]       cv;

        logic             v_d, v_q;
        logic             c_d, c_q;
        logic [WIDTH-1:0] xs_d, xs_q;
        logic [WIDTH-1:YL] y_d, y_q;

        if (k == 0) begin : g_src
            // First stage takes the operation straight from the ports.
            always_comb begin
                v_i  = in_valid;
                c_i  = c_in0;
                xs_i = X;
                yg_i = y_eff[3:0];
                yr_i = y_eff[WIDTH-1:YL];
            end
        end else begin : g_src
            // Later stages consume the previous stage register.
            always_comb begin
                v_i  = g_stage[k-1].v_q;
                c_i  = g_stage[k-1].c_q;
                xs_i = g_stage[k-1].xs_q;
                yg_i = g_stage[k-1].y_q[LO+3:LO];
                yr_i = g_stage[k-1].y_q[WIDTH-1:YL];
            end
        end

        // Evaluate group k and load the stage register unless stalled.
        always_comb begin
            cv   = cla_carries(xs_i[LO+3:LO], yg_i, c_i);
            v_d  = v_q;
            c_d  = c_q;
            xs_d = xs_q;
            y_d  = y_q;
            if (adv) begin
                v_d  = v_i;
                c_d  = cv[4];
                xs_d = xs_i;
                xs_d[LO+3:LO] = xs_i[LO+3:LO] ^ yg_i ^ cv[3:0];
                y_d  = yr_i;
            end
        end

        // Stage register; cleared by reset so in-flight work is dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                c_q  <= 1'b0;
                xs_q <= '0;
                y_q  <= '0;
            end else begin
                v_q  <= v_d;
                c_q  <= c_d;
                xs_q <= xs_d;
                y_q  <= y_d;
            end
        end
    end

    if (NG == 1) begin : g_last_src
        // Single group: the output stage is the only stage.
        always_comb begin
            lst_v  = in_valid;
            lst_c  = c_in0;
            lst_xs = X;
            lst_y  = y_eff[3:0];
        end
    end else begin : g_last_src
        // Output stage fed by the last intermediate stage.
        always_comb begin
            lst_v  = g_stage[NG-2].v_q;
            lst_c  = g_stage[NG-2].c_q;
            lst_xs = g_stage[NG-2].xs_q;
            lst_y  = g_stage[NG-2].y_q[WIDTH-1:WIDTH-4];
        end
    end

    logic [4:0]       lst_cv;
    logic [WIDTH-1:0] res;

    // Top group plus flags; data only changes when a valid result lands.
    always_comb begin
        lst_cv = cla_carries(lst_xs[WIDTH-1:WIDTH-4], lst_y, lst_c);
        res    = lst_xs;
        res[WIDTH-1:WIDTH-4] = lst_xs[WIDTH-1:WIDTH-4] ^ lst_y ^ lst_cv[3:0];
        out_valid_d = out_valid_q;
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (adv) begin
            out_valid_d = lst_v;
            if (lst_v) begin
                s_d    = res;
                cout_d = lst_cv[4];
                ovf_d  = lst_cv[4] ^ lst_cv[3];
                zero_d = (res == '0);
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder at WIDTH 16, 4 and 32 sharing one clock.
// Scoreboard queues hold expected results; outputs are checked on handshake.
module tb_cla_pipe_adder;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          cyc;
        int          stl;
    } exp_t;

    localparam int WD [3] = '{16, 4, 32};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv [3];
    logic        ir [3];
    logic        ordy [3];
    logic        ov [3];
    logic [31:0] xa [3];
    logic [31:0] ya [3];
    logic        ci [3];
    logic        sb [3];
    logic [31:0] sa [3];
    logic        co [3];
    logic        of [3];
    logic        zr [3];

    logic        r16, v16, c16, o16, z16;
    logic [15:0] s16;
    logic        r4, v4, c4, o4, z4;
    logic [3:0]  s4;
    logic        r32, v32, c32, o32, z32;
    logic [31:0] s32;

    cla_pipe_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(r16),
        .X(xa[0][15:0]), .Y(ya[0][15:0]),
        .Cin(ci[0]), .Sub(sb[0]),
        .out_valid(v16), .out_ready(ordy[0]),
        .S(s16), .Cout(c16), .Ovf(o16), .Zero(z16)
    );

    cla_pipe_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(r4),
        .X(xa[1][3:0]), .Y(ya[1][3:0]),
        .Cin(ci[1]), .Sub(sb[1]),
        .out_valid(v4), .out_ready(ordy[1]),
        .S(s4), .Cout(c4), .Ovf(o4), .Zero(z4)
    );

    cla_pipe_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(r32),
        .X(xa[2]), .Y(ya[2]),
        .Cin(ci[2]), .Sub(sb[2]),
        .out_valid(v32), .out_ready(ordy[2]),
        .S(s32), .Cout(c32), .Ovf(o32), .Zero(z32)
    );

    assign ir[0] = r16;
    assign ov[0] = v16;
    assign sa[0] = {16'b0, s16};
    assign co[0] = c16;
    assign of[0] = o16;
    assign zr[0] = z16;
    assign ir[1] = r4;
    assign ov[1] = v4;
    assign sa[1] = {28'b0, s4};
    assign co[1] = c4;
    assign of[1] = o4;
    assign zr[1] = z4;
    assign ir[2] = r32;
    assign ov[2] = v32;
    assign sa[2] = s32;
    assign co[2] = c32;
    assign of[2] = o32;
    assign zr[2] = z32;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int stl_cnt [3];
    int n_pop [3];
    int last_pop [3];
    logic held [3];
    logic acc [3];
    logic [31:0] ps [3];
    logic pc [3];
    logic po [3];
    logic pz [3];

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    endtask

    function automatic exp_t model(input int w, input logic [31:0] x,
                                   input logic [31:0] y, input logic cin,
                                   input logic sub);
        exp_t r;
        logic [63:0] m, lm, xx, yy, full, low;
        logic c0;
        m    = (64'd1 << w) - 64'd1;
        lm   = (64'd1 << (w - 1)) - 64'd1;
        xx   = {32'b0, x} & m;
        yy   = {32'b0, (sub ? ~y : y)} & m;
        c0   = cin ^ sub;
        full = xx + yy + {63'b0, c0};
        low  = (xx & lm) + (yy & lm) + {63'b0, c0};
        r.s   = full[31:0] & m[31:0];
        r.c   = full[w];
        r.o   = full[w] ^ low[w-1];
        r.z   = ((full & m) == 64'd0);
        r.cyc = 0;
        r.stl = 0;
        return r;
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int i, output exp_t e);
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // One clock cycle: inputs are already driven; check, then advance.
    task automatic tick();
        exp_t e;
        logic stl;
        string w;
        #1;
        for (int i = 0; i < 3; i++) begin
            w   = $sformatf("w%0d", WD[i]);
            stl = ov[i] & !ordy[i];
            chk({w, "_in_ready"}, ir[i], !stl);
            if (held[i]) begin
                chk({w, "_hold_valid"}, ov[i], 1);
                chk({w, "_hold_S"}, sa[i], ps[i]);
                chk({w, "_hold_flags"}, {co[i], of[i], zr[i]},
                    {pc[i], po[i], pz[i]});
            end
            acc[i] = iv[i] & ir[i];
            if (ov[i] & ordy[i]) begin
                chk({w, "_sb_entry"}, qsize(i) != 0, 1);
                if (qsize(i) != 0) begin
                    qpop(i, e);
                    chk({w, "_S"}, sa[i], e.s);
                    chk({w, "_Cout"}, co[i], e.c);
                    chk({w, "_Ovf"}, of[i], e.o);
                    chk({w, "_Zero"}, zr[i], e.z);
                    chk({w, "_latency"}, cyc - e.cyc,
                        WD[i] / 4 + stl_cnt[i] - e.stl);
                end
                n_pop[i]++;
                last_pop[i] = cyc;
            end
            if (acc[i]) begin
                e = model(WD[i], xa[i], ya[i], ci[i], sb[i]);
                e.cyc = cyc;
                e.stl = stl_cnt[i];
                qpush(i, e);
            end
            held[i] = stl;
            ps[i] = sa[i];
            pc[i] = co[i];
            po[i] = of[i];
            pz[i] = zr[i];
            if (stl) stl_cnt[i]++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_w%0d_valid", tag, WD[i]), ov[i], 0);
            chk($sformatf("%s_w%0d_S", tag, WD[i]), sa[i], 0);
            chk($sformatf("%s_w%0d_flags", tag, WD[i]),
                {co[i], of[i], zr[i]}, 0);
            chk($sformatf("%s_w%0d_in_ready", tag, WD[i]), ir[i], 1);
        end
    endtask

    logic [15:0] dx [6];
    logic [15:0] dy [6];
    logic        dc [6];
    logic        ds [6];
    int j, sl, first_acc, p0, issued;

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; xa[i] = '0; ya[i] = '0;
            ci[i] = 1'b0; sb[i] = 1'b0; stl_cnt[i] = 0; n_pop[i] = 0;
            last_pop[i] = 0; held[i] = 1'b0; acc[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // Directed WIDTH=16 operations, full rate.
        dx = '{16'h00FF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0005, 16'hFFFF};
        dy = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0000};
        dc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ds = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            iv[0] = 1'b1; xa[0] = {16'b0, dx[k]}; ya[0] = {16'b0, dy[k]};
            ci[0] = dc[k]; sb[0] = ds[k];
            tick();
        end
        iv[0] = 1'b0;
        repeat (6) tick();
        chk("w16_directed_pops", n_pop[0], 6);

        // Eight back-to-back ops with a 3-cycle backpressure window.
        j = 0; sl = 0; first_acc = -1; p0 = n_pop[0];
        for (int t = 0; t < 40 && (n_pop[0] - p0) < 8; t++) begin
            iv[0] = (j < 8);
            xa[0] = 32'(j);
            ya[0] = 32'(15 - 2 * j);
            ci[0] = 1'b0; sb[0] = 1'b0;
            if (ov[0] && sl < 3) begin
                ordy[0] = 1'b0; sl++;
            end else begin
                ordy[0] = 1'b1;
            end
            p0 = p0;
            if (j == 0) first_acc = cyc;
            tick();
            if (acc[0]) j++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        chk("w16_stream_count", n_pop[0] - p0, 8);
        chk("w16_stream_cycles", last_pop[0] - first_acc, 14);

        // Two ops in flight, then an asynchronous reset pulse.
        iv[0] = 1'b1; xa[0] = 32'h1234; ya[0] = 32'h1111; sb[0] = 1'b0;
        tick();
        xa[0] = 32'hAAAA; ya[0] = 32'h5555; sb[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        #2;
        rst_n = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        for (int i = 0; i < 3; i++) held[i] = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        p0 = n_pop[0];
        iv[0] = 1'b1; xa[0] = 32'h0F0F; ya[0] = 32'hF0F0;
        ci[0] = 1'b1; sb[0] = 1'b0;
        tick();
        iv[0] = 1'b0; ci[0] = 1'b0;
        repeat (8) tick();
        chk("w16_after_reset_pops", n_pop[0] - p0, 1);

        // WIDTH=4 exhaustive at full rate.
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++) begin
                        iv[1] = 1'b1; xa[1] = 32'(x); ya[1] = 32'(y);
                        ci[1] = c[0]; sb[1] = s[0];
                        tick();
                    end
        iv[1] = 1'b0;
        repeat (3) tick();
        chk("w4_pops", n_pop[1], 1024);
        chk("w4_drain", qsize(1), 0);

        // WIDTH=32 random stream with random valid and backpressure.
        issued = 0;
        for (int t = 0; t < 20000 && issued < 1000; t++) begin
            iv[2]   = ($urandom_range(0, 3) != 0);
            xa[2]   = $urandom;
            ya[2]   = $urandom;
            ci[2]   = 1'($urandom_range(0, 1));
            sb[2]   = 1'($urandom_range(0, 1));
            ordy[2] = ($urandom_range(0, 3) != 0);
            tick();
            if (acc[2]) issued++;
        end
        iv[2] = 1'b0; ordy[2] = 1'b1;
        repeat (20) tick();
        chk("w32_issued", issued, 1000);
        chk("w32_pops", n_pop[2], 1000);
        chk("w32_drain", qsize(2), 0);
        chk("w16_drain", qsize(0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
